// File: rtl/spice_node_integrator_pkg.sv
// Shared types and helpers for the per-node voltage integrator.
// The rail macros normally come from common.h, which is shared with the device models.
// They are only supplied here if that header has not already been seen, so they are never redefined.
`ifndef W
`define W 16
`endif
`ifndef HI
`define HI 16383
`endif
`ifndef LO
`define LO (-16384)
`endif

package spice_node_integrator_pkg;

    localparam int V_W   = `W;
    localparam int CNT_W = 8;

    // What the node registers do on a given cycle, highest priority first: load, step, hold
    typedef enum logic [1:0] {
        UPD_HOLD = 2'd0,
        UPD_STEP = 2'd1,
        UPD_LOAD = 2'd2
    } upd_mode_e;

    // Width that holds the exact sum of n_in signed voltage-width currents
    function automatic int sum_width(input int n_in);
        return V_W + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/spice_current_sum.sv
// Combinational sum of all signed currents attached to one node, in a width that cannot overflow.
module spice_current_sum
    import spice_node_integrator_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int SW   = sum_width(N_IN)
) (
    input  logic [N_IN*V_W-1:0] i_flat,
    output logic signed [SW-1:0] sum
);

    // Sign-extend every terminal current and accumulate; synthesis balances this into a tree
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            sum = sum + SW'($signed(i_flat[k*V_W +: V_W]));
        end
    end

endmodule

// File: rtl/spice_node_integrator.sv
// Per-node state element: integrates the summed terminal currents into a rail-clamped voltage,
// and derives a hysteretic logic level plus a settled flag for the latch and pin stages.
module spice_node_integrator
    import spice_node_integrator_pkg::*;
#(
    parameter int N_IN     = 8,
    parameter int SHIFT    = 0,
    parameter int TOL      = 2,
    parameter int SETTLE_N = 4,
    parameter logic signed [`W-1:0] INIT   = '0,
    parameter logic signed [`W-1:0] VTH_HI = `W'(`HI / 4),
    parameter logic signed [`W-1:0] VTH_LO = `W'(`LO / 4)
) (
    input  logic                     eclk,
    input  logic                     ereset_n,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [`W-1:0]     load_v,
    input  logic [N_IN*`W-1:0]       i_flat,
    output logic signed [`W-1:0]     v,
    output logic                     p,
    output logic                     settled,
    output logic                     clamped
);

    localparam int SW = sum_width(N_IN);
    // One extra bit so v + delta and |delta| are both exact
    localparam int EW = SW + 1;

    localparam logic signed [EW-1:0] HI_E     = EW'(`HI);
    localparam logic signed [EW-1:0] LO_E     = EW'(`LO);
    localparam logic signed [EW-1:0] TOL_E    = EW'(TOL);
    localparam logic [CNT_W-1:0]     SETTLE_C = CNT_W'(SETTLE_N);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] delta;
    logic signed [EW-1:0] delta_e;
    logic signed [EW-1:0] abs_delta;
    logic signed [EW-1:0] nxt_e;
    logic signed [EW-1:0] nxt_clamp;
    logic signed [EW-1:0] load_e;
    logic signed [EW-1:0] load_clamp;
    logic                 nxt_hit;
    logic                 load_hit;
    logic                 quiet;
    logic [CNT_W-1:0]     quiet_cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    upd_mode_e            mode;

    function automatic logic signed [EW-1:0] clamp_rail(input logic signed [EW-1:0] x);
        if (x > HI_E) begin
            return HI_E;
        end else if (x < LO_E) begin
            return LO_E;
        end
        return x;
    endfunction

    spice_current_sum #(
        .N_IN (N_IN),
        .SW   (SW)
    ) u_sum (
        .i_flat (i_flat),
        .sum    (sum)
    );

    // Next-state arithmetic: scaled delta, clamped candidate voltages and the quiet-step counter
    always_comb begin
        delta      = sum >>> SHIFT;
        delta_e    = EW'(delta);
        abs_delta  = delta_e[EW-1] ? -delta_e : delta_e;
        quiet      = (abs_delta <= TOL_E);
        nxt_e      = EW'(v) + delta_e;
        nxt_clamp  = clamp_rail(nxt_e);
        nxt_hit    = (nxt_clamp != nxt_e);
        load_e     = EW'(load_v);
        load_clamp = clamp_rail(load_e);
        load_hit   = (load_clamp != load_e);
        if (!quiet) begin
            cnt_nxt = '0;
        end else if (quiet_cnt >= SETTLE_C) begin
            cnt_nxt = SETTLE_C;
        end else begin
            cnt_nxt = quiet_cnt + CNT_W'(1);
        end
        if (load) begin
            mode = UPD_LOAD;
        end else if (en) begin
            mode = UPD_STEP;
        end else begin
            mode = UPD_HOLD;
        end
    end

    // Node voltage, rail-hit pulse and settle tracking, updated by load, step or hold
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            v         <= INIT;
            clamped   <= 1'b0;
            quiet_cnt <= '0;
            settled   <= 1'b0;
        end else begin
            case (mode)
                UPD_LOAD: begin
                    v         <= load_clamp[`W-1:0];
                    clamped   <= load_hit;
                    quiet_cnt <= '0;
                    settled   <= 1'b0;
                end
                UPD_STEP: begin
                    v         <= nxt_clamp[`W-1:0];
                    clamped   <= nxt_hit;
                    quiet_cnt <= cnt_nxt;
                    settled   <= (cnt_nxt == SETTLE_C);
                end
                default: begin
                    clamped   <= 1'b0;
                end
            endcase
        end
    end

    // Hysteretic logic level, following the registered voltage every cycle
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            p <= 1'b0;
        end else if (v > VTH_HI) begin
            p <= 1'b1;
        end else if (v < VTH_LO) begin
            p <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spice_node_integrator.sv
// Bench for spice_node_integrator: directed vector table, hand-written reset/priority
// sequences, and randomized steps checked against a behavioural node model.
module tb_spice_node_integrator;

    localparam int N_IN     = 4;
    localparam int SHIFT    = 0;
    localparam int TOL      = 2;
    localparam int SETTLE_N = 4;
    localparam int RAIL_HI  = 16383;
    localparam int RAIL_LO  = -16384;
    localparam int TH_HI    = RAIL_HI / 4;
    localparam int TH_LO    = RAIL_LO / 4;

    logic                eclk = 1'b0;
    logic                ereset_n = 1'b0;
    logic                en = 1'b0;
    logic                load = 1'b0;
    logic signed [15:0]  load_v = '0;
    logic [N_IN*16-1:0]  i_flat = '0;
    logic signed [15:0]  v;
    logic                p;
    logic                settled;
    logic                clamped;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural node state
    int m_v;
    int m_cnt;
    bit m_p;
    bit m_settled;
    bit m_clamped;

    typedef struct {
        bit ld;
        bit step;
        int lv;
        int c0;
        int c1;
        int c2;
        int c3;
        int ev;
        bit ep;
        bit es;
        bit ec;
    } vec_t;

    vec_t tbl[25];

    spice_node_integrator #(
        .N_IN     (N_IN),
        .SHIFT    (SHIFT),
        .TOL      (TOL),
        .SETTLE_N (SETTLE_N),
        .INIT     (16'sd0)
    ) dut (
        .eclk     (eclk),
        .ereset_n (ereset_n),
        .en       (en),
        .load     (load),
        .load_v   (load_v),
        .i_flat   (i_flat),
        .v        (v),
        .p        (p),
        .settled  (settled),
        .clamped  (clamped)
    );

    always #5 eclk = ~eclk;

    function automatic int clamp_rail(input int x);
        if (x > RAIL_HI) return RAIL_HI;
        if (x < RAIL_LO) return RAIL_LO;
        return x;
    endfunction

    task automatic modelReset();
        m_v = 0;
        m_cnt = 0;
        m_p = 1'b0;
        m_settled = 1'b0;
        m_clamped = 1'b0;
    endtask

    // Drive one step, wait for the edge, then advance the model by the rules of the node
    task automatic applyStimulus(input bit ld, input bit step, input int lv,
                                 input int c0, input int c1, input int c2, input int c3);
        int raw;
        int d;
        int mag;
        load   = ld;
        en     = step;
        load_v = 16'(lv);
        i_flat = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        @(posedge eclk);
        #1;
        if (m_v > TH_HI) m_p = 1'b1;
        else if (m_v < TH_LO) m_p = 1'b0;
        if (ld) begin
            m_v = clamp_rail(lv);
            m_clamped = (m_v != lv);
            m_cnt = 0;
            m_settled = 1'b0;
        end else if (step) begin
            d = (c0 + c1 + c2 + c3) >>> SHIFT;
            raw = m_v + d;
            m_v = clamp_rail(raw);
            m_clamped = (m_v != raw);
            mag = (d < 0) ? -d : d;
            if (mag <= TOL) m_cnt = (m_cnt + 1 > SETTLE_N) ? SETTLE_N : m_cnt + 1;
            else m_cnt = 0;
            m_settled = (m_cnt == SETTLE_N);
        end else begin
            m_clamped = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name);
        vectors++;
        if (v !== 16'(m_v) || p !== m_p || settled !== m_settled || clamped !== m_clamped) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%0d p=%b settled=%b clamped=%b, expected v=%0d p=%b settled=%b clamped=%b",
                     name, v, p, settled, clamped, m_v, m_p, m_settled, m_clamped);
        end
    endtask

    task automatic checkConst(input string name, input int ev, input bit ep, input bit es, input bit ec);
        vectors++;
        if (v !== 16'(ev) || p !== ep || settled !== es || clamped !== ec) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%0d p=%b settled=%b clamped=%b, expected v=%0d p=%b settled=%b clamped=%b",
                     name, v, p, settled, clamped, ev, ep, es, ec);
        end
    endtask

    initial begin
        // Integrate, clamp, hysteresis, settle and saturation, starting from v=0 after reset
        tbl[0]  = '{0, 1, 0, 100, 50, -30, 0,  120, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 100, 50, -30, 0,  240, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 100, 50, -30, 0,  360, 0, 0, 0};
        tbl[3]  = '{1, 0, 16000, 0, 0, 0, 0,   16000, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 1000, 0, 0, 0,    16383, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 1000, 0, 0, 0,    16383, 1, 0, 1};
        tbl[6]  = '{1, 0, -20000, 0, 0, 0, 0,  -16384, 1, 0, 1};
        tbl[7]  = '{1, 0, 5000, 0, 0, 0, 0,    5000, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,       5000, 1, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 0,       0, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0,       0, 1, 0, 0};
        tbl[11] = '{1, 0, -5000, 0, 0, 0, 0,   -5000, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0,       -5000, 0, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 1, 1, 0, -1,      1, 0, 0, 0};
        tbl[16] = '{0, 1, 0, 1, 1, 0, -1,      2, 0, 0, 0};
        tbl[17] = '{0, 1, 0, 1, 1, 0, -1,      3, 0, 0, 0};
        tbl[18] = '{0, 1, 0, 1, 1, 0, -1,      4, 0, 1, 0};
        tbl[19] = '{0, 1, 0, 3, 0, 0, 0,       7, 0, 0, 0};
        tbl[20] = '{0, 1, 0, 1, 1, 0, -1,      8, 0, 0, 0};
        tbl[21] = '{0, 1, 0, 1, 1, 0, -1,      9, 0, 0, 0};
        tbl[22] = '{0, 1, 0, 1, 1, 0, -1,      10, 0, 0, 0};
        tbl[23] = '{0, 1, 0, 1, 1, 0, -1,      11, 0, 1, 0};
        tbl[24] = '{0, 1, 0, 1, 1, 0, -1,      12, 0, 1, 0};

        // Reset held with enable and currents active: outputs must stay at reset values
        modelReset();
        en = 1'b1;
        i_flat = {16'sd0, -16'sd30, 16'sd50, 16'sd100};
        #1;
        checkConst("reset_async", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge eclk);
            #1;
            checkConst("reset_hold", 0, 0, 0, 0);
        end
        ereset_n = 1'b1;
        #1;
        checkConst("reset_release", 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i].ld, tbl[i].step, tbl[i].lv, tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].c3);
            checkConst($sformatf("table_%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].es, tbl[i].ec);
            checkOutput($sformatf("table_model_%0d", i));
        end

        // Idle cycles: voltage and settled flag must hold
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 3000, 3000, 0, 0);
            checkConst("idle_hold", 12, 0, 1, 0);
        end

        // Load beats enable and clears settled
        applyStimulus(1, 1, 777, 500, 0, 0, 0);
        checkConst("priority_load", 777, 0, 0, 0);

        // Reset asserted mid-cycle alongside load/en wins immediately
        load = 1'b1;
        en = 1'b1;
        load_v = 16'sd777;
        i_flat = {16'sd0, 16'sd0, 16'sd0, 16'sd500};
        #2;
        ereset_n = 1'b0;
        #1;
        modelReset();
        checkConst("priority_reset", 0, 0, 0, 0);
        @(posedge eclk);
        #1;
        checkConst("priority_reset_edge", 0, 0, 0, 0);
        load = 1'b0;
        en = 1'b0;
        ereset_n = 1'b1;

        // Randomized steps against the model
        for (int i = 0; i < 400; i++) begin
            bit ld;
            bit st;
            int lv;
            int c[4];
            ld = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) != 0);
            lv = int'($urandom_range(0, 65535)) - 32768;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 0) c[k] = int'($urandom_range(0, 2)) - 1;
                else c[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 4; k++) c[k] = int'($urandom_range(0, 2)) - 1;
            end
            applyStimulus(ld, st, lv, c[0], c[1], c[2], c[3]);
            checkOutput($sformatf("random_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
